// File: rtl/pyramid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pyramid_pkg                                                       |
// | Brief  : Shared types and default geometry for the pyramid stream scaler.  |
// |          Defaults come from the vj_weights.vh macros when they are         |
// |          defined, otherwise from a small 8x6, three-level fallback.        |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 8
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 6
`endif
`ifndef PYRAMID_LEVELS
`define PYRAMID_LEVELS 3
`endif
`ifndef PYRAMID_STEPS
`define PYRAMID_STEPS {32'h0001_9000, 32'h0001_4000, 32'h0001_0000}
`endif
`ifndef PYRAMID_WIDTHS
`define PYRAMID_WIDTHS {32'd5, 32'd6, 32'd8}
`endif
`ifndef PYRAMID_HEIGHTS
`define PYRAMID_HEIGHTS {32'd3, 32'd4, 32'd6}
`endif

package pyramid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } scaler_state_t;

  // Unsigned fixed-point sampling step; fraction width is a module parameter.
  typedef logic [31:0] step_t;

  localparam int unsigned DEFAULT_SRC_WIDTH  = `LAPTOP_WIDTH;
  localparam int unsigned DEFAULT_SRC_HEIGHT = `LAPTOP_HEIGHT;
  localparam int unsigned DEFAULT_LEVELS     = `PYRAMID_LEVELS;

  // Packed per-level tables, level 0 in the least significant word.
  localparam step_t [DEFAULT_LEVELS-1:0]       DEFAULT_STEPS       = `PYRAMID_STEPS;
  localparam logic  [DEFAULT_LEVELS-1:0][31:0] DEFAULT_OUT_WIDTHS  = `PYRAMID_WIDTHS;
  localparam logic  [DEFAULT_LEVELS-1:0][31:0] DEFAULT_OUT_HEIGHTS = `PYRAMID_HEIGHTS;

endpackage

`default_nettype wire

// File: rtl/axis_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : axis_sampler                                                      |
// | Brief  : One nearest-neighbour sampling axis: source coordinate counter,   |
// |          fixed-point sampling accumulator and output index counter.        |
// | Ports  : clk, rst_n      - clock, asynchronous active-low reset            |
// |          clear           - frame start; current beat is coordinate 0       |
// |          tick            - advance the source coordinate this cycle        |
// |          gate            - extra qualifier for selection                   |
// |          step, limit     - accumulator step and output count limit         |
// |          last            - current coordinate is the last source one       |
// |          sel             - current coordinate lands on the sampling grid   |
// |          first_out       - output index is 0                               |
// |          last_out        - output index is limit-1                         |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module axis_sampler
  import pyramid_pkg::*;
#(
  parameter int unsigned SRC_N     = 8,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        tick,
  input  logic        gate,
  input  step_t       step,
  input  logic [31:0] limit,
  output logic        last,
  output logic        sel,
  output logic        first_out,
  output logic        last_out
);

  localparam int unsigned c_pos_w = (SRC_N > 1) ? $clog2(SRC_N) : 1;
  localparam int unsigned c_acc_w = c_pos_w + FRAC_BITS + 1;

  logic [c_pos_w-1:0] r_pos;
  logic [c_acc_w-1:0] r_acc;
  logic [31:0]        r_cnt;

  logic [c_pos_w-1:0] w_pos;
  logic [c_acc_w-1:0] w_acc;
  logic [31:0]        w_cnt;

  // A clearing beat is itself coordinate 0, so it sees zeroed state
  // combinationally rather than waiting a cycle for the registers.
  assign w_pos = clear ? '0 : r_pos;
  assign w_acc = clear ? '0 : r_acc;
  assign w_cnt = clear ? '0 : r_cnt;

  assign last      = (w_pos == c_pos_w'(SRC_N - 1));
  assign sel       = gate && ({1'b0, w_pos} == w_acc[c_acc_w-1:FRAC_BITS]) && (w_cnt < limit);
  assign first_out = (w_cnt == 32'd0);
  assign last_out  = (w_cnt == limit - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (tick) begin
      if (last) begin
        r_pos <= '0;
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_pos <= w_pos + c_pos_w'(1);
        r_acc <= sel ? (w_acc + c_acc_w'(step)) : w_acc;
        r_cnt <= sel ? (w_cnt + 32'd1) : w_cnt;
      end
    end else if (clear) begin
      r_pos <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pyramid_stream_scaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pyramid_stream_scaler                                             |
// | Brief  : Streaming nearest-neighbour downscaler for one pyramid level per  |
// |          frame. Forwards source pixels on the level's sampling grid with   |
// |          sof/eol/eof markers through a single output register.             |
// | Ports  : clock, reset_n        - clock, asynchronous active-low reset      |
// |          level                 - pyramid index, latched on accepted sof    |
// |          in_pixel/sof/valid    - source stream, in_ready back-pressure     |
// |          out_pixel/sof/eol/eof - selected pixel and markers                |
// |          out_valid/out_ready   - sink handshake                            |
// |          busy                  - frame in progress                         |
// |          level_err             - sticky out-of-range level flag            |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module pyramid_stream_scaler
  import pyramid_pkg::*;
#(
  parameter int unsigned                PIXEL_W     = 32,
  parameter int unsigned                SRC_WIDTH   = DEFAULT_SRC_WIDTH,
  parameter int unsigned                SRC_HEIGHT  = DEFAULT_SRC_HEIGHT,
  parameter int unsigned                LEVELS      = DEFAULT_LEVELS,
  parameter int unsigned                FRAC_BITS   = 16,
  parameter step_t [LEVELS-1:0]         STEPS       = DEFAULT_STEPS,
  parameter logic  [LEVELS-1:0][31:0]   OUT_WIDTHS  = DEFAULT_OUT_WIDTHS,
  parameter logic  [LEVELS-1:0][31:0]   OUT_HEIGHTS = DEFAULT_OUT_HEIGHTS
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [3:0]         level,
  input  logic [PIXEL_W-1:0] in_pixel,
  input  logic               in_sof,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [PIXEL_W-1:0] out_pixel,
  output logic               out_sof,
  output logic               out_eol,
  output logic               out_eof,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               level_err
);

  localparam int unsigned c_lvl_w = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  scaler_state_t      r_state;
  scaler_state_t      w_state_next;
  logic [3:0]         r_level;
  logic               r_busy;
  logic               r_level_err;
  logic [PIXEL_W-1:0] r_out_pixel;
  logic               r_out_sof;
  logic               r_out_eol;
  logic               r_out_eof;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_start;
  logic [3:0]         w_lvl_eff;
  logic               w_lvl_bad;
  logic [c_lvl_w-1:0] w_lvl_idx;
  logic               w_process;
  logic               w_active;
  logic               w_sel;
  logic               w_frame_last;

  logic w_x_last, w_x_sel, w_x_first, w_x_last_out;
  logic w_y_last, w_y_sel, w_y_first, w_y_last_out;

  // Back-pressure depends only on the output register, never on in_*.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_start  = w_accept && in_sof;

  // An sof beat uses its own level in the same cycle it is latched.
  assign w_lvl_eff = w_start ? level : r_level;
  assign w_lvl_bad = (32'(w_lvl_eff) >= LEVELS);
  assign w_lvl_idx = w_lvl_bad ? '0 : w_lvl_eff[c_lvl_w-1:0];

  assign w_process    = w_accept && (w_start || (r_state != ST_IDLE));
  assign w_active     = w_process && (w_start ? !w_lvl_bad : (r_state == ST_ACTIVE));
  assign w_sel        = w_active && w_x_sel;
  assign w_frame_last = w_process && w_x_last && w_y_last;

  axis_sampler #(
    .SRC_N     (SRC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_x_sampler (
    .clk       (clock),
    .rst_n     (reset_n),
    .clear     (w_start),
    .tick      (w_process),
    .gate      (w_y_sel),
    .step      (STEPS[w_lvl_idx]),
    .limit     (OUT_WIDTHS[w_lvl_idx]),
    .last      (w_x_last),
    .sel       (w_x_sel),
    .first_out (w_x_first),
    .last_out  (w_x_last_out)
  );

  // The row axis advances once per source row, at its last column.
  axis_sampler #(
    .SRC_N     (SRC_HEIGHT),
    .FRAC_BITS (FRAC_BITS)
  ) u_y_sampler (
    .clk       (clock),
    .rst_n     (reset_n),
    .clear     (w_start),
    .tick      (w_process && w_x_last),
    .gate      (1'b1),
    .step      (STEPS[w_lvl_idx]),
    .limit     (OUT_HEIGHTS[w_lvl_idx]),
    .last      (w_y_last),
    .sel       (w_y_sel),
    .first_out (w_y_first),
    .last_out  (w_y_last_out)
  );

  // Frame end follows the source count; a mid-frame sof simply restarts.
  always_comb begin
    w_state_next = r_state;
    if (w_frame_last) begin
      w_state_next = ST_IDLE;
    end else if (w_start) begin
      w_state_next = w_lvl_bad ? ST_DROP : ST_ACTIVE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_level     <= '0;
      r_busy      <= 1'b0;
      r_level_err <= 1'b0;
      r_out_pixel <= '0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Held one extra cycle past the last source beat to cover its output.
      r_busy  <= (w_state_next != ST_IDLE) || w_frame_last;
      if (w_start) begin
        r_level <= level;
      end
      if (w_start && w_lvl_bad) begin
        r_level_err <= 1'b1;
      end
      if (w_sel) begin
        r_out_valid <= 1'b1;
        r_out_pixel <= in_pixel;
        r_out_sof   <= w_x_first && w_y_first;
        r_out_eol   <= w_x_last_out;
        r_out_eof   <= w_x_last_out && w_y_last_out;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_pixel = r_out_pixel;
  assign out_sof   = r_out_sof;
  assign out_eol   = r_out_eol;
  assign out_eof   = r_out_eof;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign level_err = r_level_err;

endmodule

`default_nettype wire

// File: doc/pyramid_stream_scaler.md
# pyramid_stream_scaler

Streaming nearest-neighbour downscaler for the face-detection image pyramid. It accepts one source frame in raster order over a valid/ready stream. For the pyramid level latched at start of frame, it forwards only the source pixels that land on the level's sampling grid, with row/frame markers. It replaces the all-pixels-at-once combinational downscale between the frame buffer and the integral-image / window-scan stages, and supports any level count and image size through parameters.

## Interface
- `PIXEL_W`, 32, pixel word width
- `SRC_WIDTH`, `LAPTOP_WIDTH, source columns
- `SRC_HEIGHT`, `LAPTOP_HEIGHT, source rows
- `LEVELS`, `PYRAMID_LEVELS, number of pyramid levels
- `FRAC_BITS`, 16, fractional bits of step values
- `STEPS`, `PYRAMID_STEPS, [LEVELS][32] unsigned fixed-point step per level, level 0 = 1.0
- `OUT_WIDTHS`, `PYRAMID_WIDTHS, [LEVELS][32] output columns per level
- `OUT_HEIGHTS`, `PYRAMID_HEIGHTS, [LEVELS][32] output rows per level

Ports:
- `clock` in 1: single clock
- `reset_n` in 1: asynchronous, active-low reset
- `level` in 4: pyramid index, sampled on accepted `in_sof` beat
- `in_pixel` in PIXEL_W: source pixel
- `in_sof` in 1: first pixel of frame
- `in_valid` in 1 / `in_ready` out 1: source handshake
- `out_pixel` out PIXEL_W: selected pixel
- `out_sof` / `out_eol` / `out_eof` out 1: first of frame / last of output row / last of frame
- `out_valid` out 1 / `out_ready` in 1: sink handshake
- `busy` out 1: frame in progress
- `level_err` out 1: sticky, set when latched `level` ≥ LEVELS

## Operation
- States are IDLE, ACTIVE and DROP.
- **IDLE:** beats without `in_sof` are accepted and discarded. An accepted `in_sof` beat latches `level`:
  - If `level` < LEVELS, go to ACTIVE.
  - Otherwise set `level_err` and go to DROP.
  - The `in_sof` beat itself is processed as source (0,0).
- **Counters:**
  - Source counters `src_x` (0..SRC_WIDTH-1) and `src_y` (0..SRC_HEIGHT-1) advance on every accepted beat in ACTIVE/DROP.
  - `src_x` wraps to 0 and increments `src_y`.
- **Sampling accumulators:**
  - Accumulators `nx` and `ny` are each $clog2(SRC)+FRAC_BITS+1 bits, unsigned, and reset to 0 at frame start.
  - A row is selected when `src_y == ny[int]` and `out_row < OUT_HEIGHTS[level]`.
  - In a selected row, a pixel is selected when `src_x == nx[int]` and `out_col < OUT_WIDTHS[level]`.
  - On each selected pixel: `nx += STEPS[level]` and `out_col++`.
  - At the end of each source row: `nx ← 0`, `out_col ← 0`.
  - At the end of a selected row: `ny += STEP`, `out_row++`.
  - STEP ≥ 1.0, so there is at most one output per source pixel and one output row per source row.
- **Output markers:**
  - `out_sof` is set on output (0,0).
  - `out_eol` is set when `out_col == OUT_WIDTHS-1`.
  - `out_eof` is set on the last column of the last output row.
- **Frame end:** after the beat with `src_x=SRC_WIDTH-1, src_y=SRC_HEIGHT-1`, go to IDLE. The frame end is based on the source count, not the output count.
- **DROP:** accepts and discards a full source frame, then returns to IDLE. No output is produced.
- **Mid-frame `in_sof`** in ACTIVE/DROP: the frame is aborted. The beat is treated as a new frame start in the same cycle: re-latch level, clear counters and accumulators. An output already registered still drains. No `out_eof` is emitted for the aborted frame.
- `level_err` clears only on reset.

## Timing
- Output is a single register stage; latency is 1 cycle from an accepted selected beat to `out_valid`.
- `in_ready = !out_valid || out_ready`. This holds in all states for simplicity, so there are no combinational paths from `in_*` to `out_*`.
- `out_*` are held stable while `out_valid && !out_ready`.
- Throughput is one source beat per cycle with no stalls when the sink is always ready.
- Reset values: `out_valid`, `out_sof`, `out_eol`, `out_eof`, `busy` and `level_err` are 0; `out_pixel` is 0; state is IDLE; all counters are 0.
- Reset asserted mid-frame discards all state immediately; the first post-reset frame needs a fresh `in_sof`.
- `busy` is 1 from the cycle after `in_sof` acceptance through the cycle after the last source beat.

## Structure
- Package `pyramid_pkg`:
  - holds state enum `scaler_state_t`;
  - provides default `STEPS`/`OUT_WIDTHS`/`OUT_HEIGHTS` localparams built from `vj_weights.vh` macros;
  - provides a `step_t` typedef.
- Sub-module `axis_sampler` contains one accumulator-compare unit (count, accumulate, select). It is instantiated twice, once for x and once for y.

## Test plan
- Params 8×6, FRAC_BITS=16, level 1 step 0x14000, out 6×4, sink always ready:
  - Outputs are source x = 0,1,2,3,5,6 and y = 0,1,2,3.
  - That gives 24 beats, `out_eol` on every 6th beat, `out_eof` on the 24th.
- Level 0 (step 0x10000, 8×6): every pixel passes with latency 1. There are 48 outputs, and the `in_ready` stream is continuous.
- Level 2 step 0x19000, out 5×3:
  - Columns are 0,1,3,4,6.
  - Rows are 0,1,3; source row 4 (ny=4.6875→4) is excluded by the height limit.
- Random `out_ready` (~50%) at level 1:
  - The output sequence is identical to the first scenario.
  - No beat is lost or duplicated, and `out_*` stays stable under stall.
- Edge cases:
  - `level=12` on sof: `level_err`=1 and 48 beats are consumed with no output.
  - The next frame at level 1 produces normal output.
- Abort and reset mid-frame:
  - Sof re-asserted at source beat 20 restarts the frame, with `out_sof` on the next output.
  - `reset_n` low mid-frame clears all outputs to 0 asynchronously.
